// File: rtl/ghost_mover_if.sv
`default_nettype none
// ============================================================================
// Module     : ghost_mover_if
// Description: Request, board-read and result signals of the ghost motion stage.
// Revision   : 1.0
// ============================================================================
interface ghost_mover_if;
    logic       start;
    logic       frightened;
    logic [4:0] pac_x;
    logic [4:0] pac_y;
    logic [9:0] rd_addr;
    logic [3:0] rd_data;
    logic [4:0] cur_x;
    logic [4:0] cur_y;
    logic [4:0] old_x;
    logic [4:0] old_y;
    logic [1:0] dir;
    logic       busy;
    logic       done;

    modport master (
        output start, frightened, pac_x, pac_y, rd_data,
        input  rd_addr, cur_x, cur_y, old_x, old_y, dir, busy, done
    );

    modport slave (
        input  start, frightened, pac_x, pac_y, rd_data,
        output rd_addr, cur_x, cur_y, old_x, old_y, dir, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ghost_mover.sv
`default_nettype none
// ============================================================================
// Module     : ghost_mover
// Description: Probes the four board tiles around the ghost, then takes one
//              chase or random step, avoiding reversal when possible.
// Revision   : 1.0
// ============================================================================
module ghost_mover #(
    parameter int         START_X   = 13,
    parameter int         START_Y   = 11,
    parameter logic [3:0] WALL_CODE = 4'd1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    ghost_mover_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_P0     = 3'd1;
    localparam logic [2:0] S_P1     = 3'd2;
    localparam logic [2:0] S_P2     = 3'd3;
    localparam logic [2:0] S_P3     = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DECIDE = 3'd6;

    localparam logic [4:0] C_MAX_X = 5'd27;
    localparam logic [4:0] C_MAX_Y = 5'd30;

    logic [2:0]  r_state;
    logic [4:0]  r_cur_x;
    logic [4:0]  r_cur_y;
    logic [4:0]  r_old_x;
    logic [4:0]  r_old_y;
    logic [1:0]  r_dir;
    logic [9:0]  r_rd_addr;
    logic        r_done;
    logic [3:0]  r_open;
    logic [15:0] r_lfsr;

    logic [4:0]  w_nx [4];
    logic [4:0]  w_ny [4];
    logic [9:0]  w_addr [4];
    logic [5:0]  w_dist [4];
    logic [3:0]  w_blocked;
    logic        w_sample_open;
    logic [15:0] w_lfsr_next;
    logic [3:0]  w_rev_mask;
    logic [3:0]  w_fwd;
    logic [3:0]  w_cand;
    logic [1:0]  w_chase;
    logic [5:0]  w_best;
    logic        w_found;
    logic [1:0]  w_rnd;
    logic        w_rnd_found;
    logic [1:0]  w_idx;
    logic [1:0]  w_pick;

    // Neighbour order: 0 up, 1 left, 2 down, 3 right; columns wrap through the tunnel.
    always_comb begin
        w_nx[0] = r_cur_x;
        w_ny[0] = r_cur_y - 5'd1;
        w_nx[1] = (r_cur_x == 5'd0) ? C_MAX_X : r_cur_x - 5'd1;
        w_ny[1] = r_cur_y;
        w_nx[2] = r_cur_x;
        w_ny[2] = r_cur_y + 5'd1;
        w_nx[3] = (r_cur_x == C_MAX_X) ? 5'd0 : r_cur_x + 5'd1;
        w_ny[3] = r_cur_y;
        w_blocked = {1'b0, (r_cur_y == C_MAX_Y), 1'b0, (r_cur_y == 5'd0)};
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_nbr
            logic [4:0] w_dx;
            logic [4:0] w_dy;
            assign w_addr[k] = w_blocked[k] ? 10'd0
                             : ({5'd0, w_ny[k]} * 10'd28) + {5'd0, w_nx[k]};
            assign w_dx = (w_nx[k] >= bus.pac_x) ? (w_nx[k] - bus.pac_x) : (bus.pac_x - w_nx[k]);
            assign w_dy = (w_ny[k] >= bus.pac_y) ? (w_ny[k] - bus.pac_y) : (bus.pac_y - w_ny[k]);
            assign w_dist[k] = {1'b0, w_dx} + {1'b0, w_dy};
        end
    endgenerate

    assign w_sample_open = (bus.rd_data != WALL_CODE);
    assign w_lfsr_next   = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    // Reversing is only allowed when it is the sole way out.
    assign w_rev_mask = 4'b0001 << (r_dir ^ 2'd2);
    assign w_fwd      = r_open & ~w_rev_mask;
    assign w_cand     = (w_fwd != 4'd0) ? w_fwd : r_open;

    always_comb begin
        w_chase = 2'd0;
        w_best  = 6'h3f;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_cand[i] && (!w_found || (w_dist[i] < w_best))) begin
                w_found = 1'b1;
                w_best  = w_dist[i];
                w_chase = 2'(i);
            end
        end
    end

    always_comb begin
        w_rnd       = 2'd0;
        w_rnd_found = 1'b0;
        w_idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_lfsr[1:0] + 2'(i);
            if (!w_rnd_found && w_cand[w_idx]) begin
                w_rnd_found = 1'b1;
                w_rnd       = w_idx;
            end
        end
    end

    assign w_pick = bus.frightened ? w_rnd : w_chase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cur_x   <= 5'(START_X);
            r_cur_y   <= 5'(START_Y);
            r_old_x   <= 5'(START_X);
            r_old_y   <= 5'(START_Y);
            r_dir     <= 2'd0;
            r_rd_addr <= 10'd0;
            r_done    <= 1'b0;
            r_open    <= 4'd0;
            r_lfsr    <= SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_P0;
                        r_rd_addr <= w_addr[0];
                    end
                end
                S_P0: begin
                    r_state   <= S_P1;
                    r_rd_addr <= w_addr[1];
                end
                // Read data lags the address by one cycle: each state samples the previous probe.
                S_P1: begin
                    r_open[0] <= w_sample_open & ~w_blocked[0];
                    r_state   <= S_P2;
                    r_rd_addr <= w_addr[2];
                end
                S_P2: begin
                    r_open[1] <= w_sample_open & ~w_blocked[1];
                    r_state   <= S_P3;
                    r_rd_addr <= w_addr[3];
                end
                S_P3: begin
                    r_open[2] <= w_sample_open & ~w_blocked[2];
                    r_state   <= S_DRAIN;
                    r_rd_addr <= 10'd0;
                end
                S_DRAIN: begin
                    r_open[3] <= w_sample_open & ~w_blocked[3];
                    r_state   <= S_DECIDE;
                end
                S_DECIDE: begin
                    r_old_x <= r_cur_x;
                    r_old_y <= r_cur_y;
                    if (w_cand != 4'd0) begin
                        r_cur_x <= w_nx[w_pick];
                        r_cur_y <= w_ny[w_pick];
                        r_dir   <= w_pick;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr = r_rd_addr;
    assign bus.cur_x   = r_cur_x;
    assign bus.cur_y   = r_cur_y;
    assign bus.old_x   = r_old_x;
    assign bus.old_y   = r_old_y;
    assign bus.dir     = r_dir;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;

endmodule
`default_nettype wire
